alu_arbiter: RTL
================

# alu_arbiter

Shares the single combinational `alu` between `NREQ` requesters, for example the execute stage and the branch/compare unit. Each requester uses a valid/ready request handshake. Requests are granted round-robin, and the ALU output is captured into one response register that is returned to the granted requester under its own valid/ready handshake. The block sits between the requesters and the `alu` instance it owns.

## Interface
**Parameters**
- `NREQ`, default 2: number of requesters (2..8).
- `IDW`, default `$clog2(NREQ)`: requester index width.

**Ports** (format: name, direction, width, meaning)
- `clk`, in, 1: sole clock.
- `rst_n`, in, 1: synchronous, active-low reset.
- `req_valid`, in, NREQ: request present, per requester.
- `req_ready`, out, NREQ: request accepted this cycle, one-hot or zero.
- `req_srca`, in, NREQ×32: operand A per requester.
- `req_srcb`, in, NREQ×32: operand B per requester.
- `req_ctrl`, in, NREQ×5: ALU control code per requester.
- `rsp_valid`, out, NREQ: response held for requester i, one-hot or zero.
- `rsp_ready`, in, NREQ: requester consumes its response.
- `rsp_res`, out, 32: registered ALU result.
- `rsp_flag`, out, 1: registered ALU flag.
- `rsp_err`, out, 1: the request carried an undefined control code (greater than 5'b10001).

## Operation
- **States.** The response slot has two states, `EMPTY` and `FULL`.
- **Slot free.** `slot_free = EMPTY | (FULL & rsp_valid[owner] & rsp_ready[owner])`.
- **Grant.** When `slot_free` is high and any `req_valid` is high, `rr_arbiter` picks requester g.
  - g is the first valid requester starting from pointer `prio`, searching upward with wrap-around modulo NREQ.
  - `req_ready[g]=1`; all other ready bits are 0.
- **ALU drive.** The ALU is fed `req_srca[g]`, `req_srcb[g]` and `req_ctrl[g]` in the grant cycle.
- **Capture.** On the next edge:
  - `rsp_res` and `rsp_flag` capture the ALU output, `owner<=g`, and the state goes to `FULL`.
  - `prio<=(g+1)%NREQ`.
- **Undefined control code.** `rsp_res=0`, `rsp_flag=0`, `rsp_err=1`; the ALU's X outputs are never registered. For valid codes `rsp_err=0`.
- **Hold.** In `FULL`, `rsp_*` stay stable until popped.
- **Pop.**
  - Pop with no new grant: the state goes to `EMPTY`, and `rsp_valid` drops on the next cycle.
  - Pop and grant in the same cycle: the slot reloads with no bubble, and `owner` may change.
- **No grant.** With no valid requests, `prio` is unchanged.
- **Requester obligations.** Once `req_valid` is asserted it must be held with stable payload until `req_ready` is seen. A requester may deassert `rsp_ready` indefinitely; this stalls all requesters.
- **Ready rules.** `req_ready` is never asserted while `rst_n=0`. `req_ready` depends combinationally on `req_valid`, `rsp_ready` and state; there is no combinational path from `req_*` to `rsp_*`.

## Timing
- **Reset values:**
  - state `EMPTY`, `prio=0`, `owner=0`;
  - `rsp_valid=0`, `rsp_res=0`, `rsp_flag=0`, `rsp_err=0`;
  - `req_ready=0` while in reset.
- **Latency:** grant at cycle N gives `rsp_valid` at N+1.
- **Throughput:** 1 op/cycle when the owner holds `rsp_ready=1`.
- **Reset mid-operation:** a held response is discarded; no `rsp_valid` pulse follows reset.
- **Simultaneous requests:** all NREQ valid every cycle gives grants 0,1,…,NREQ-1,0,…, so each requester is served within NREQ grants (starvation-free).
- **Pointer wrap:** after granting NREQ-1, `prio` returns to 0.

## Structure
- **`alu_pkg`:**
  - `alu_op_t` enum: `ALU_MOV`=0, `ADD`, `SUB`, `AND`, `OR`, `XOR`, `SLL`, `SRL`, `SRA`, `EQ`, `NE`, `LTU`, `GTU`, `GEU`, `LT`, `GT`, `GE`, `LUI`=5'b10001.
  - `ALU_OP_LAST` = 5'b10001, used for the `rsp_err` check.
- **`rr_arbiter`:** `NREQ`, `req` and `prio` in; one-hot `gnt` and encoded index out; combinational.
- **`alu_arbiter`:** instantiates `rr_arbiter` and the existing `alu`.

## Test plan
- **Single request.** After reset, req0: srca=5, srcb=7, ctrl=ADD, `rsp_ready=1`. Expect `req_ready[0]` in cycle N, then `rsp_valid=01`, `rsp_res=12`, `rsp_flag=0` at N+1.
- **Round-robin.** Both requesters valid continuously with SUB (srca=1, srcb=10) and EQ (srca=3, srcb=3). Expect grants 0,1,0,1; responses res=9/flag 0 and res=1/flag 1; back-to-back with no bubbles.
- **Backpressure.** req1 granted, `rsp_ready[1]=0` for 5 cycles while req0 is valid. Expect no `req_ready[0]` and `rsp_res` stable. When `rsp_ready[1]=1`, req0 is granted in that same cycle and `rsp_valid=01` on the next cycle.
- **Undefined code.** ctrl=5'b11111. Expect `rsp_res=0`, `rsp_flag=0`, `rsp_err=1`; a following LUI with srcb=0x1234 gives `rsp_res=0x12340000`, `rsp_err=0`.
- **Reset mid-operation.** `rst_n=0` while `FULL` and unpopped. Expect `rsp_valid=0`, `rsp_res=0`, `req_ready=0` in reset. After release with both requesters valid, requester 0 is granted first (`prio=0`).
- **Signed compare and wrap.** NREQ=3, all valid, each requester sending LT with srcb=0xFFFFFFFF, srca=1. Expect grants 0,1,2,0 and every result res=1, flag=1.

Source files
------------

// File: rtl/alu_pkg.sv
// +--------------------------------------------------------------------+
// | alu_pkg : ALU opcode encoding shared by alu and alu_arbiter        |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
`default_nettype none

package alu_pkg;

    typedef enum logic [4:0] {
        ALU_MOV = 5'b00000,
        ALU_ADD,
        ALU_SUB,
        ALU_AND,
        ALU_OR,
        ALU_XOR,
        ALU_SLL,
        ALU_SRL,
        ALU_SRA,
        ALU_EQ,
        ALU_NE,
        ALU_LTU,
        ALU_GTU,
        ALU_GEU,
        ALU_LT,
        ALU_GT,
        ALU_GE,
        ALU_LUI = 5'b10001
    } alu_op_t;

    localparam logic [4:0] ALU_OP_LAST = 5'b10001;

    function automatic logic is_undef_op(input logic [4:0] ctrl);
        return ctrl > ALU_OP_LAST;
    endfunction

endpackage

`default_nettype wire

// File: rtl/alu.sv
// +--------------------------------------------------------------------+
// | alu : combinational 32-bit ALU; compares evaluate srcb OP srca     |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
`default_nettype none

module alu
    import alu_pkg::*;
(
    input  logic [31:0] srca,
    input  logic [31:0] srcb,
    input  logic [4:0]  ctrl,
    output logic [31:0] res,
    output logic        flag
);

    logic w_slt;
    logic w_ult;

    assign w_slt = $signed(srcb) < $signed(srca);
    assign w_ult = srcb < srca;

    always_comb begin
        res  = 'x;
        flag = 1'b0;
        case (ctrl)
            ALU_MOV: res = srca;
            ALU_ADD: res = srcb + srca;
            ALU_SUB: res = srcb - srca;
            ALU_AND: res = srcb & srca;
            ALU_OR:  res = srcb | srca;
            ALU_XOR: res = srcb ^ srca;
            ALU_SLL: res = srcb << srca[4:0];
            ALU_SRL: res = srcb >> srca[4:0];
            ALU_SRA: res = $unsigned($signed(srcb) >>> srca[4:0]);
            ALU_EQ:  flag = (srcb == srca);
            ALU_NE:  flag = (srcb != srca);
            ALU_LTU: flag = w_ult;
            ALU_GTU: flag = (srcb > srca);
            ALU_GEU: flag = !w_ult;
            ALU_LT:  flag = w_slt;
            ALU_GT:  flag = ($signed(srcb) > $signed(srca));
            ALU_GE:  flag = !w_slt;
            ALU_LUI: res = {srcb[15:0], 16'h0000};
            default: begin
                res  = 'x;
                flag = 1'bx;
            end
        endcase
        // Compare ops return the flag as a 0/1 result as well.
        if (ctrl >= ALU_EQ && ctrl <= ALU_GE) begin
            res = {31'b0, flag};
        end
    end

endmodule

`default_nettype wire

// File: rtl/rr_arbiter.sv
// +--------------------------------------------------------------------+
// | rr_arbiter : combinational round-robin pick starting at prio       |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
`default_nettype none

module rr_arbiter #(
    parameter int NREQ = 2,
    parameter int IDW  = $clog2(NREQ)
) (
    input  logic [NREQ-1:0] req,
    input  logic [IDW-1:0]  prio,
    output logic [NREQ-1:0] gnt,
    output logic [IDW-1:0]  idx
);

    int   w_j;
    logic w_found;

    always_comb begin
        gnt     = '0;
        idx     = '0;
        w_found = 1'b0;
        w_j     = 0;
        for (int k = 0; k < NREQ; k++) begin
            w_j = int'(prio) + k;
            if (w_j >= NREQ) begin
                w_j = w_j - NREQ;
            end
            if (!w_found && req[w_j]) begin
                w_found  = 1'b1;
                gnt[w_j] = 1'b1;
                idx      = IDW'(w_j);
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/alu_arbiter.sv
// +--------------------------------------------------------------------+
// | alu_arbiter : round-robin sharing of one ALU, one response slot    |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
`default_nettype none

module alu_arbiter
    import alu_pkg::*;
#(
    parameter int NREQ = 2,
    parameter int IDW  = $clog2(NREQ)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [NREQ-1:0]       req_valid,
    output logic [NREQ-1:0]       req_ready,
    input  logic [NREQ-1:0][31:0] req_srca,
    input  logic [NREQ-1:0][31:0] req_srcb,
    input  logic [NREQ-1:0][4:0]  req_ctrl,
    output logic [NREQ-1:0]       rsp_valid,
    input  logic [NREQ-1:0]       rsp_ready,
    output logic [31:0]           rsp_res,
    output logic                  rsp_flag,
    output logic                  rsp_err
);

    localparam logic [0:0] c_EMPTY = 1'b0;
    localparam logic [0:0] c_FULL  = 1'b1;

    logic [0:0]      r_state;
    logic [0:0]      w_state_nxt;
    logic [IDW-1:0]  r_prio;
    logic [IDW-1:0]  r_owner;
    logic [31:0]     r_res;
    logic            r_flag;
    logic            r_err;

    logic [NREQ-1:0] w_gnt;
    logic [IDW-1:0]  w_gnt_idx;
    logic [IDW-1:0]  w_prio_nxt;
    logic            w_pop;
    logic            w_slot_free;
    logic            w_grant;

    logic [31:0]     w_srca;
    logic [31:0]     w_srcb;
    logic [4:0]      w_ctrl;
    logic [31:0]     w_alu_res;
    logic            w_alu_flag;
    logic            w_err;

    rr_arbiter #(
        .NREQ (NREQ),
        .IDW  (IDW)
    ) u_rr_arbiter (
        .req  (req_valid),
        .prio (r_prio),
        .gnt  (w_gnt),
        .idx  (w_gnt_idx)
    );

    assign w_srca = req_srca[w_gnt_idx];
    assign w_srcb = req_srcb[w_gnt_idx];
    assign w_ctrl = req_ctrl[w_gnt_idx];

    alu u_alu (
        .srca (w_srca),
        .srcb (w_srcb),
        .ctrl (w_ctrl),
        .res  (w_alu_res),
        .flag (w_alu_flag)
    );

    assign w_err       = is_undef_op(w_ctrl);
    assign w_pop       = (r_state == c_FULL) && rsp_ready[r_owner];
    assign w_slot_free = (r_state == c_EMPTY) || w_pop;
    assign w_grant     = rst_n && w_slot_free && (|req_valid);
    assign w_prio_nxt  = (w_gnt_idx == IDW'(NREQ - 1)) ? '0 : w_gnt_idx + 1'b1;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= c_EMPTY;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        if (w_grant) begin
            w_state_nxt = c_FULL;
        end else if (w_pop) begin
            w_state_nxt = c_EMPTY;
        end
    end

    always_comb begin
        req_ready = '0;
        rsp_valid = '0;
        if (w_grant) begin
            req_ready = w_gnt;
        end
        if (r_state == c_FULL) begin
            rsp_valid[r_owner] = 1'b1;
        end
    end

    // Undefined codes are masked here so the ALU's X outputs never reach a flop.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_prio  <= '0;
            r_owner <= '0;
            r_res   <= '0;
            r_flag  <= 1'b0;
            r_err   <= 1'b0;
        end else if (w_grant) begin
            r_prio  <= w_prio_nxt;
            r_owner <= w_gnt_idx;
            r_res   <= w_err ? 32'h0 : w_alu_res;
            r_flag  <= w_err ? 1'b0 : w_alu_flag;
            r_err   <= w_err;
        end
    end

    assign rsp_res  = r_res;
    assign rsp_flag = r_flag;
    assign rsp_err  = r_err;

endmodule

`default_nettype wire
